// File: rtl/cobra_bus_map_pkg.sv
// Shared constants, FSM state types and the masked port-compare helper
// used throughout the cobra_bus_map slice.
package cobra_bus_pkg;

    localparam logic [15:0] DEF_RELOC_MASK = 16'hC000;
    localparam logic [7:0]  DEF_RELOC_PORT = 8'h1F;
    localparam logic [7:0]  DEF_PORT_MASK  = 8'hFF;
    localparam logic [7:0]  DEF_OUT_BASE   = 8'hF0;
    localparam logic [7:0]  DEF_IN_PORT    = 8'hFE;

    typedef enum logic [1:0] {IO_IDLE, IO_WR_HOLD, IO_BLOCK} io_state_e;
    typedef enum logic [1:0] {W_IDLE, W_COUNT, W_HOLD} wait_state_e;

    // Only the address bits selected by mask take part in the compare.
    function automatic logic port_match(input logic [7:0] addr,
                                        input logic [7:0] port,
                                        input logic [7:0] mask);
        return (addr & mask) == (port & mask);
    endfunction

endpackage

// File: rtl/cobra_bus_map_if.sv
// Bus bundle between the tv80s-side master and the cobra_bus_map controller.
interface cobra_bus_map_if #(
    parameter int N_OUT = 4
) ();
    logic [15:0]        cpu_a;
    logic [7:0]         cpu_dout;
    logic               mreq_n;
    logic               iorq_n;
    logic               rd_n;
    logic               wr_n;
    logic               m1_n;
    logic               rfsh_n;
    logic [7:0]         cpu_din;
    logic               wait_n;
    logic [15:0]        mem_addr;
    logic [7:0]         mem_dout;
    logic [7:0]         in_data;
    logic [N_OUT*8-1:0] out_q;
    logic [N_OUT-1:0]   out_stb;
    logic               reloc_active;

    modport master (
        output cpu_a, cpu_dout, mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n,
               mem_dout, in_data,
        input  cpu_din, wait_n, mem_addr, out_q, out_stb, reloc_active
    );

    modport slave (
        input  cpu_a, cpu_dout, mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n,
               mem_dout, in_data,
        output cpu_din, wait_n, mem_addr, out_q, out_stb, reloc_active
    );
endinterface

// File: rtl/cobra_bus_map_wait_gen.sv
// cobra_wait_gen: stretches each non-refresh memory cycle by WAIT_CYC wait
// states; wait_n drops combinationally in the first cycle of the access.
module cobra_wait_gen
    import cobra_bus_pkg::*;
#(
    parameter int WAIT_CYC = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic mreq_n,
    input  logic rd_n,
    input  logic wr_n,
    input  logic m1_n,
    input  logic rfsh_n,
    output logic wait_n
);
    localparam logic [3:0] LOAD = 4'(WAIT_CYC);

    wait_state_e r_state;
    wait_state_e w_state_next;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_next;
    logic        w_wait_n;
    logic        w_mem_cyc;

    assign w_mem_cyc = ~mreq_n & (~rd_n | ~wr_n | ~m1_n) & rfsh_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= W_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // The idle cycle that detects the access already counts as the first wait state.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_wait_n     = 1'b1;
        case (r_state)
            W_IDLE: begin
                if (w_mem_cyc) begin
                    if (LOAD == 4'd0) begin
                        w_state_next = W_HOLD;
                    end else begin
                        w_wait_n     = 1'b0;
                        w_cnt_next   = LOAD;
                        w_state_next = W_COUNT;
                    end
                end
            end
            W_COUNT: begin
                w_wait_n = (r_cnt <= 4'd1);
                if (mreq_n) begin
                    w_state_next = W_IDLE;
                    w_cnt_next   = '0;
                end else if (r_cnt <= 4'd1) begin
                    w_state_next = W_HOLD;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            W_HOLD: begin
                if (mreq_n) w_state_next = W_IDLE;
            end
            default: w_state_next = W_IDLE;
        endcase
    end

    assign wait_n = reset | w_wait_n;

endmodule

// File: rtl/cobra_bus_map.sv
// cobra_bus_map: relocation overlay, I/O output latches with strobes, read mux.
// Define MEM_WAIT_EN to build in the memory wait-state generator.
module cobra_bus_map
    import cobra_bus_pkg::*;
#(
    parameter logic [15:0] RELOC_MASK = DEF_RELOC_MASK,
    parameter logic [7:0]  RELOC_PORT = DEF_RELOC_PORT,
    parameter logic [7:0]  PORT_MASK  = DEF_PORT_MASK,
    parameter int          N_OUT      = 4,
    parameter logic [7:0]  OUT_BASE   = DEF_OUT_BASE,
    parameter logic [7:0]  IN_PORT    = DEF_IN_PORT,
    parameter int          WAIT_CYC   = 2
) (
    input logic            clk,
    input logic            reset,
    cobra_bus_map_if.slave bus
);
    io_state_e          r_io_state;
    io_state_e          w_io_state_next;
    logic               r_reloc;
    logic [7:0]         r_out_q [N_OUT];
    logic [N_OUT-1:0]   r_out_stb;
    logic [N_OUT-1:0]   w_ch_match;
    logic [N_OUT*8-1:0] w_out_q_flat;
    logic               w_io_wr;
    logic               w_io_rd;
    logic               w_inta;
    logic               w_wr_accept;
    logic               w_ch_hit;
    logic [7:0]         w_ch_data;
    logic [7:0]         w_cpu_din;

    assign w_io_wr = ~bus.iorq_n & ~bus.wr_n & bus.m1_n;
    assign w_io_rd = ~bus.iorq_n & ~bus.rd_n;
    assign w_inta  = ~bus.m1_n & ~bus.iorq_n;

    generate
        for (genvar gi = 0; gi < N_OUT; gi++) begin : g_ch
            assign w_ch_match[gi] = port_match(bus.cpu_a[7:0], OUT_BASE + 8'(gi), PORT_MASK);

            always_ff @(posedge clk or posedge reset) begin
                if (reset)
                    r_out_q[gi] <= '0;
                else if (w_wr_accept && w_ch_match[gi])
                    r_out_q[gi] <= bus.cpu_dout;
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_io_state <= IO_BLOCK;
            r_out_stb  <= '0;
        end else begin
            r_io_state <= w_io_state_next;
            r_out_stb  <= {N_OUT{w_wr_accept}} & w_ch_match;
        end
    end

    // IO_BLOCK keeps a write that straddles reset release from being taken as new.
    always_comb begin
        w_io_state_next = r_io_state;
        w_wr_accept     = 1'b0;
        case (r_io_state)
            IO_IDLE: begin
                if (w_io_wr) begin
                    w_wr_accept     = 1'b1;
                    w_io_state_next = IO_WR_HOLD;
                end
            end
            IO_WR_HOLD, IO_BLOCK: begin
                if (bus.iorq_n) w_io_state_next = IO_IDLE;
            end
            default: w_io_state_next = IO_BLOCK;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_reloc <= 1'b1;
        else if (w_io_wr && port_match(bus.cpu_a[7:0], RELOC_PORT, PORT_MASK))
            r_reloc <= 1'b0;
    end

    // Scan high to low so the lowest matching channel wins on aliasing.
    always_comb begin
        w_ch_hit  = 1'b0;
        w_ch_data = 8'hFF;
        for (int i = N_OUT - 1; i >= 0; i--) begin
            if (w_ch_match[i]) begin
                w_ch_hit  = 1'b1;
                w_ch_data = r_out_q[i];
            end
        end
    end

    always_comb begin
        w_out_q_flat = '0;
        for (int i = 0; i < N_OUT; i++) w_out_q_flat[8*i +: 8] = r_out_q[i];
    end

    always_comb begin
        w_cpu_din = 8'hFF;
        if (!bus.mreq_n)
            w_cpu_din = bus.mem_dout;
        else if (w_inta)
            w_cpu_din = 8'hFF;
        else if (w_io_rd && w_ch_hit)
            w_cpu_din = w_ch_data;
        else if (w_io_rd && port_match(bus.cpu_a[7:0], IN_PORT, PORT_MASK))
            w_cpu_din = bus.in_data;
    end

    assign bus.cpu_din      = w_cpu_din;
    assign bus.mem_addr     = r_reloc ? (bus.cpu_a | RELOC_MASK) : bus.cpu_a;
    assign bus.out_q        = w_out_q_flat;
    assign bus.out_stb      = r_out_stb;
    assign bus.reloc_active = r_reloc;

`ifdef MEM_WAIT_EN
    cobra_wait_gen #(
        .WAIT_CYC (WAIT_CYC)
    ) u_wait_gen (
        .clk    (clk),
        .reset  (reset),
        .mreq_n (bus.mreq_n),
        .rd_n   (bus.rd_n),
        .wr_n   (bus.wr_n),
        .m1_n   (bus.m1_n),
        .rfsh_n (bus.rfsh_n),
        .wait_n (bus.wait_n)
    );
`else
    localparam int UNUSED_WAIT_CYC = WAIT_CYC;
    logic w_unused_rfsh;
    assign w_unused_rfsh = bus.rfsh_n;
    assign bus.wait_n    = 1'b1;
`endif

endmodule

// File: tb/tb_cobra_bus_map.sv
// Randomised bench for cobra_bus_map: two instances (full and aliased port mask)
// checked every cycle against a behavioural model of the bus rules.
module tb_cobra_bus_map;
    localparam int NO = 4;
`ifdef MEM_WAIT_EN
    localparam int WC0 = 2;
`else
    localparam int WC0 = 0;
`endif
    localparam int K_IDLE = 0, K_MRD = 1, K_MWR = 2, K_M1 = 3, K_RFSH = 4,
                   K_IOWR = 5, K_IORD = 6, K_INTA = 7;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_a;
    logic [7:0]  cpu_dout, mem_dout, in_data;
    logic        mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n;

    int n_total = 0;
    int n_bad   = 0;
    int n_stb2, n_stbany, n_wlow0, n_wlow1;

    always #5 clk = ~clk;

    cobra_bus_map_if #(.N_OUT(NO)) bus0 ();
    cobra_bus_map_if #(.N_OUT(NO)) bus1 ();

    assign bus0.cpu_a = cpu_a;     assign bus1.cpu_a = cpu_a;
    assign bus0.cpu_dout = cpu_dout; assign bus1.cpu_dout = cpu_dout;
    assign bus0.mreq_n = mreq_n;   assign bus1.mreq_n = mreq_n;
    assign bus0.iorq_n = iorq_n;   assign bus1.iorq_n = iorq_n;
    assign bus0.rd_n = rd_n;       assign bus1.rd_n = rd_n;
    assign bus0.wr_n = wr_n;       assign bus1.wr_n = wr_n;
    assign bus0.m1_n = m1_n;       assign bus1.m1_n = m1_n;
    assign bus0.rfsh_n = rfsh_n;   assign bus1.rfsh_n = rfsh_n;
    assign bus0.mem_dout = mem_dout; assign bus1.mem_dout = mem_dout;
    assign bus0.in_data = in_data; assign bus1.in_data = in_data;

    cobra_bus_map #(.N_OUT(NO), .WAIT_CYC(WC0)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0.slave));
    cobra_bus_map #(.PORT_MASK(8'h1F), .N_OUT(NO), .WAIT_CYC(0)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1.slave));

    // Reference model state, index 0 = dut0, 1 = dut1
    logic [7:0]    pmask [2] = '{8'hFF, 8'h1F};
    int            wcyc  [2] = '{WC0, 0};
    logic          m_reloc [2];
    logic [7:0]    m_q [2][NO];
    logic [NO-1:0] m_stb [2];
    logic          m_armed [2];
    logic          m_inmem [2];
    int            m_age [2];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic pm(input int d, input logic [7:0] a, input logic [7:0] p);
        return (a & pmask[d]) == (p & pmask[d]);
    endfunction

    function automatic logic mem_cycle();
        return !mreq_n && (!rd_n || !wr_n || !m1_n) && rfsh_n;
    endfunction

    task automatic model_reset(input int d);
        m_reloc[d] = 1'b1;
        for (int i = 0; i < NO; i++) m_q[d][i] = 8'h00;
        m_stb[d]   = '0;
        m_armed[d] = 1'b0;
        m_inmem[d] = 1'b0;
        m_age[d]   = 0;
    endtask

    function automatic logic [7:0] exp_din(input int d);
        if (!mreq_n) return mem_dout;
        if (!m1_n && !iorq_n) return 8'hFF;
        if (!iorq_n && !rd_n) begin
            for (int i = 0; i < NO; i++)
                if (pm(d, cpu_a[7:0], 8'hF0 + 8'(i))) return m_q[d][i];
            if (pm(d, cpu_a[7:0], 8'hFE)) return in_data;
        end
        return 8'hFF;
    endfunction

    function automatic logic exp_wait(input int d);
        if (reset) return 1'b1;
        if (m_inmem[d]) return !(m_age[d] < wcyc[d]);
        if (mem_cycle()) return !(wcyc[d] > 0);
        return 1'b1;
    endfunction

    task automatic model_step(input int d);
        logic          iowr;
        logic [NO-1:0] s;
        if (reset) begin
            model_reset(d);
            return;
        end
        iowr = !iorq_n && !wr_n && m1_n;
        s = '0;
        if (iowr && pm(d, cpu_a[7:0], 8'h1F)) m_reloc[d] = 1'b0;
        if (iowr && m_armed[d])
            for (int i = 0; i < NO; i++)
                if (pm(d, cpu_a[7:0], 8'hF0 + 8'(i))) begin
                    m_q[d][i] = cpu_dout;
                    s[i] = 1'b1;
                end
        m_stb[d] = s;
        if (iorq_n) m_armed[d] = 1'b1;
        else if (iowr) m_armed[d] = 1'b0;
        if (!m_inmem[d] && mem_cycle()) begin
            m_inmem[d] = 1'b1;
            m_age[d]   = 1;
        end else if (m_inmem[d]) begin
            if (mreq_n) m_inmem[d] = 1'b0;
            else m_age[d]++;
        end
    endtask

    task automatic check_dut(input int d, input logic [15:0] addr, input logic [7:0] din,
                             input logic wn, input logic rel, input logic [NO-1:0] stb,
                             input logic [8*NO-1:0] q);
        logic [8*NO-1:0] eq;
        for (int i = 0; i < NO; i++) eq[8*i +: 8] = m_q[d][i];
        check_val($sformatf("d%0d mem_addr", d), addr, m_reloc[d] ? (cpu_a | 16'hC000) : cpu_a);
        check_val($sformatf("d%0d cpu_din", d), din, exp_din(d));
        check_val($sformatf("d%0d wait_n", d), wn, exp_wait(d));
        check_val($sformatf("d%0d reloc", d), rel, m_reloc[d]);
        check_val($sformatf("d%0d out_stb", d), stb, m_stb[d]);
        check_val($sformatf("d%0d out_q", d), q, eq);
    endtask

    // Called at a falling edge with inputs already set; returns at the next falling edge.
    task automatic tick();
        #2;
        check_dut(0, bus0.mem_addr, bus0.cpu_din, bus0.wait_n, bus0.reloc_active, bus0.out_stb, bus0.out_q);
        check_dut(1, bus1.mem_addr, bus1.cpu_din, bus1.wait_n, bus1.reloc_active, bus1.out_stb, bus1.out_q);
        n_stb2   += (bus0.out_stb == 4'b0100) ? 1 : 0;
        n_stbany += (bus0.out_stb != 4'b0000) ? 1 : 0;
        n_wlow0  += bus0.wait_n ? 0 : 1;
        n_wlow1  += bus1.wait_n ? 0 : 1;
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
    endtask

    task automatic set_bus(input int kind, input logic [15:0] a, input logic [7:0] d);
        cpu_a = a; cpu_dout = d;
        mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1; rfsh_n = 1'b1;
        case (kind)
            K_MRD:  begin mreq_n = 1'b0; rd_n = 1'b0; end
            K_MWR:  begin mreq_n = 1'b0; wr_n = 1'b0; end
            K_M1:   begin mreq_n = 1'b0; rd_n = 1'b0; m1_n = 1'b0; end
            K_RFSH: begin mreq_n = 1'b0; rfsh_n = 1'b0; end
            K_IOWR: begin iorq_n = 1'b0; wr_n = 1'b0; end
            K_IORD: begin iorq_n = 1'b0; rd_n = 1'b0; end
            K_INTA: begin iorq_n = 1'b0; m1_n = 1'b0; end
            default: ;
        endcase
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset(0);
        model_reset(1);
        tick();
        tick();
        reset = 1'b0;
    endtask

    logic [7:0] port_list [10] = '{8'hF0, 8'hF1, 8'hF2, 8'hF3, 8'h1F, 8'h3F, 8'hFE, 8'h40, 8'h31, 8'h00};

    initial begin
        reset = 1'b1;
        mem_dout = 8'h00;
        in_data  = 8'h00;
        set_bus(K_IDLE, 16'h0000, 8'h00);
        @(negedge clk);
        do_reset();
        set_bus(K_IDLE, 16'h0000, 8'h00);
        tick();

        // Relocated fetch, then disable write, then plain fetch
        set_bus(K_M1, 16'h0000, 8'h00); mem_dout = 8'h3E; #1;
        check_val("fetch0 mem_addr", bus0.mem_addr, 16'hC000);
        check_val("fetch0 reloc", bus0.reloc_active, 1'b1);
        tick();
        set_bus(K_IDLE, 16'h0000, 8'h00); tick();
        set_bus(K_IOWR, 16'h551F, 8'h55); #1;
        check_val("reloc write still relocated", bus0.mem_addr, 16'hD51F);
        tick(); tick();
        set_bus(K_IDLE, 16'h0000, 8'h00); #1;
        check_val("reloc cleared", bus0.reloc_active, 1'b0);
        tick();
        set_bus(K_M1, 16'h0003, 8'h00); #1;
        check_val("fetch3 mem_addr", bus0.mem_addr, 16'h0003);
        tick();
        set_bus(K_IDLE, 16'h0000, 8'h00); tick();

        // Long write to channel 2: one strobe only
        n_stb2 = 0;
        set_bus(K_IOWR, 16'h00F2, 8'h5A);
        repeat (3) tick();
        set_bus(K_IDLE, 16'h0000, 8'h00); tick(); tick();
        check_val("outF2 q", bus0.out_q[23:16], 8'h5A);
        check_val("outF2 stb cycles", n_stb2, 1);

        set_bus(K_IORD, 16'h00F2, 8'h00); #1;
        check_val("inF2", bus0.cpu_din, 8'h5A);
        tick();
        in_data = 8'h3C;
        set_bus(K_IORD, 16'h00FE, 8'h00); #1;
        check_val("inFE", bus0.cpu_din, 8'h3C);
        tick();
        set_bus(K_IORD, 16'h0040, 8'h00); #1;
        check_val("in40", bus0.cpu_din, 8'hFF);
        tick();
        n_stbany = 0;
        set_bus(K_INTA, 16'h00F0, 8'h00); #1;
        check_val("inta din", bus0.cpu_din, 8'hFF);
        tick(); tick();
        set_bus(K_IDLE, 16'h0000, 8'h00); tick();
        check_val("inta no stb", n_stbany, 0);

        // Wait states on a read, none on refresh
        n_wlow0 = 0; n_wlow1 = 0;
        mem_dout = 8'hA7;
        set_bus(K_MRD, 16'h1234, 8'h00); #1;
        check_val("mrd din", bus0.cpu_din, 8'hA7);
        repeat (4) tick();
        set_bus(K_IDLE, 16'h0000, 8'h00); tick();
        check_val("mrd wait cycles d0", n_wlow0, WC0);
        check_val("mrd wait cycles d1", n_wlow1, 0);
        n_wlow0 = 0;
        set_bus(K_RFSH, 16'h007F, 8'h00);
        repeat (3) tick();
        set_bus(K_IDLE, 16'h0000, 8'h00); tick();
        check_val("rfsh wait cycles", n_wlow0, 0);

        // Reset in the middle of a held write to F0
        set_bus(K_IOWR, 16'h00F0, 8'h77); tick();
        do_reset();
        check_val("rst q0", bus0.out_q[7:0], 8'h00);
        n_stbany = 0;
        repeat (3) tick();
        check_val("rst held write no stb", n_stbany, 0);
        check_val("rst held write q0", bus0.out_q[7:0], 8'h00);
        set_bus(K_IDLE, 16'h0000, 8'h00); tick();
        n_stbany = 0;
        set_bus(K_IOWR, 16'h00F0, 8'h88); tick(); tick();
        set_bus(K_IDLE, 16'h0000, 8'h00); tick();
        check_val("clean write q0", bus0.out_q[7:0], 8'h88);
        check_val("clean write stb", n_stbany, 1);

        // Aliased disable port on the 5-bit-mask instance
        set_bus(K_IOWR, 16'h003F, 8'h00); tick();
        set_bus(K_IDLE, 16'h0000, 8'h00); #1;
        check_val("alias reloc d1", bus1.reloc_active, 1'b0);
        check_val("alias reloc d0", bus0.reloc_active, 1'b1);
        tick();

        for (int t = 0; t < 250; t++) begin
            int         kind, len, gap, pi;
            logic [7:0] port;
            if ($urandom_range(0, 59) == 0) begin
                $display("txn %0d reset", t);
                set_bus(K_IDLE, 16'h0000, 8'h00);
                do_reset();
                continue;
            end
            kind = $urandom_range(0, 7);
            len  = $urandom_range(1, 4);
            gap  = $urandom_range(0, 2);
            pi   = $urandom_range(0, 9);
            port = (pi == 9) ? 8'($urandom) : port_list[pi];
            mem_dout = 8'($urandom);
            in_data  = 8'($urandom);
            set_bus(kind, {8'($urandom), port}, 8'($urandom));
            $display("txn %0d kind=%0d a=%h d=%h len=%0d", t, kind, cpu_a, cpu_dout, len);
            repeat (len) tick();
            set_bus(K_IDLE, cpu_a, 8'h00);
            repeat (gap) tick();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
